otter_fetch_queue: RTL and testbench
====================================

# otter_fetch_queue

Parametrised instruction-fetch stage for the pipelined OTTER core. It owns the program counter and issues one read per cycle on memory port 1, which has 1-cycle synchronous read latency. Returned instructions are buffered with their PCs in a DEPTH-entry queue and presented to decode over a valid/ready handshake. Redirects (branch, jump, trap) flush the queue and discard any in-flight read.

## Interface
- XLEN, 32: address and instruction width.
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_VEC, 32'h0000_0000: PC fetched first after reset.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- MEM_ADDR1  out  XLEN  fetch address, equal to the current PC.
- MEM_READ1  out  1  read strobe; data returns on MEM_DOUT1 in the following cycle.
- MEM_DOUT1  in  XLEN  instruction for the read issued in the previous cycle.
- REDIRECT  in  1  one-cycle pulse that flushes the queue and sets the new PC.
- REDIRECT_PC  in  XLEN  target address; bits [1:0] are ignored and forced to 0.
- IF_VALID  out  1  queue head is valid.
- IF_READY  in  1  decode accepts the head this cycle.
- IF_IR  out  XLEN  head instruction; 32'h0000_0013 (NOP) when empty.
- IF_PC  out  XLEN  head PC; 0 when empty.
- OCCUPANCY  out  $clog2(DEPTH+1)  entries currently held.

## Operation
- State:
  - pc register.
  - inflight flag and its pc_wait tag, which holds the PC of the outstanding read.
  - kill flag.
  - DEPTH-entry circular queue of {pc, ir}, with rd_ptr, wr_ptr and count.
- Issue rule: MEM_READ1 = !RST && !REDIRECT && (count + inflight − pop) < DEPTH, where pop = IF_VALID && IF_READY.
  - On issue: pc ← pc+4, inflight ← 1, pc_wait ← pc.
  - With no issue: inflight ← 0.
- Response: when inflight && !kill, {pc_wait, MEM_DOUT1} is written at wr_ptr at the clock edge. The issue rule guarantees the queue never overflows.
- Pop and push in the same cycle: count is unchanged and both pointers advance.
- Pointer wrap: pointers are $clog2(DEPTH) bits wide and wrap naturally. Full is count == DEPTH; empty is count == 0.
- Redirect, at the edge ending cycle t:
  - count, rd_ptr and wr_ptr ← 0.
  - pc ← {REDIRECT_PC[XLEN-1:2], 2'b00}.
  - kill ← inflight. This discards the response arriving in t+1.
  - No read is issued in cycle t.
  - A pop in cycle t is still a completed handshake, and that entry is gone.
  - A response arriving in cycle t is dropped.
- Consecutive redirects: the last one wins. Every redirect cycle blocks issue.
- PC wraps modulo 2^XLEN.
- Reset mid-operation: all state clears immediately (asynchronous). The in-flight response is lost because inflight = 0.

## Timing
- Reset values:
  - pc = RESET_VEC; inflight, kill and count = 0.
  - IF_VALID = 0, IF_IR = NOP, IF_PC = 0, OCCUPANCY = 0.
  - MEM_READ1 = 0 while RST is high; MEM_ADDR1 = RESET_VEC.
- First cycle after RST falls: read of RESET_VEC issued (cycle 0). Data is captured at the end of cycle 1; IF_VALID = 1 in cycle 2.
- Redirect latency: REDIRECT in cycle t → target read in t+1 → IF_VALID with IF_PC = target in t+3.
- Steady state: with IF_READY held high, one instruction per cycle with no bubbles for DEPTH ≥ 2.
- All outputs are registered-state-derived except MEM_READ1, which depends combinationally on REDIRECT and IF_READY.

## Structure
- Shared package otter_pipe_pkg holds:
  - typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [XLEN-1:0] ir;}
  - constant OTTER_NOP = 32'h0000_0013
  - constant OTTER_RESET_VEC
- Sub-module otter_sync_fifo, parametrised on entry type and DEPTH, with push, pop, flush, count, head. otter_fetch_queue adds the PC, issue and kill logic around it.
- Target size: about 200 lines total.

## Test plan
- Reset release with IF_READY = 1 and memory returning 32'h1000_0000|addr: IF_PC sequence 0, 4, 8, 12… starting in cycle 2, one per cycle, IF_IR matching.
- IF_READY = 0 for 10 cycles, DEPTH = 4: OCCUPANCY saturates at 4, MEM_READ1 drops to 0, no entry is overwritten. On release, PCs 0, 4, 8, 12, 16 arrive in order with no gap.
- REDIRECT with REDIRECT_PC = 32'h0000_0103 while a read is in flight and 3 entries are queued:
  - OCCUPANCY = 0 the next cycle.
  - The in-flight instruction never appears.
  - The first IF_PC is 32'h0000_0100, three cycles after REDIRECT.
- REDIRECT in two consecutive cycles (targets 0x40, then 0x80): only 0x80, 0x84… appear; 0x40 never issues.
- Assert RST asynchronously mid-stream, between edges: IF_VALID and OCCUPANCY go to 0 immediately. After release, fetch restarts at RESET_VEC with no stale entry.
- Run with DEPTH = 2 and DEPTH = 8, randomised IF_READY and redirects. A scoreboard checks that every delivered {pc, ir} is in program order since the last redirect, with no duplicates and no drops.

Source files
------------

// File: rtl/otter_fetch_queue_pkg.sv
// Shared OTTER pipeline types and constants used by the fetch stage.
package otter_pipe_pkg;

  localparam int          OTTER_XLEN      = 32;
  localparam logic [31:0] OTTER_NOP       = 32'h0000_0013;
  localparam logic [31:0] OTTER_RESET_VEC = 32'h0000_0000;

  typedef struct packed {
    logic [OTTER_XLEN-1:0] pc;
    logic [OTTER_XLEN-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/otter_fetch_queue_if.sv
// Fetch-stage bundle: memory port 1 plus the valid/ready link to decode.
interface otter_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  import otter_pipe_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] MEM_ADDR1;
  logic            MEM_READ1;
  logic [XLEN-1:0] MEM_DOUT1;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            IF_VALID;
  logic            IF_READY;
  logic [XLEN-1:0] IF_IR;
  logic [XLEN-1:0] IF_PC;
  logic [CW-1:0]   OCCUPANCY;

  modport master (
    output MEM_ADDR1, MEM_READ1, IF_VALID, IF_IR, IF_PC, OCCUPANCY,
    input  MEM_DOUT1, REDIRECT, REDIRECT_PC, IF_READY
  );

  modport slave (
    input  MEM_ADDR1, MEM_READ1, IF_VALID, IF_IR, IF_PC, OCCUPANCY,
    output MEM_DOUT1, REDIRECT, REDIRECT_PC, IF_READY
  );

endinterface

// File: rtl/otter_fetch_queue_sync_fifo.sv
// Circular queue with flush; flush overrides any push or pop in the same cycle.
module otter_sync_fifo
  import otter_pipe_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output T                           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/otter_fetch_queue.sv
// OTTER fetch stage: owns the PC, issues one read per cycle and queues {pc, ir} for decode.
module otter_fetch_queue
  import otter_pipe_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(OTTER_RESET_VEC)
) (
  input logic                CLK,
  input logic                RST,
  otter_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_wait;
  logic            inflight;
  logic            kill;
  logic [CW-1:0]   count;
  entry_t          head;
  entry_t          wr_entry;
  logic            valid;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occ_after;

  assign valid    = (count != '0);
  assign pop      = valid && bus.IF_READY;
  assign push     = inflight && !kill;
  assign wr_entry = '{pc: pc_wait, ir: bus.MEM_DOUT1};

  // Reserve a slot for the outstanding read so its response can never overflow the queue.
  assign occ_after = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue     = !RST && !bus.REDIRECT && (occ_after < (CW+1)'(DEPTH));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc       <= RESET_VEC;
      pc_wait  <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else if (bus.REDIRECT) begin
      pc       <= {bus.REDIRECT_PC[XLEN-1:2], 2'b00};
      kill     <= inflight;
      inflight <= 1'b0;
    end else begin
      kill <= 1'b0;
      if (issue) begin
        pc       <= pc + XLEN'(4);
        pc_wait  <= pc;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  otter_sync_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .flush     (bus.REDIRECT),
    .count     (count),
    .head      (head)
  );

  assign bus.MEM_ADDR1 = pc;
  assign bus.MEM_READ1 = issue;
  assign bus.IF_VALID  = valid;
  assign bus.IF_IR     = valid ? head.ir : XLEN'(OTTER_NOP);
  assign bus.IF_PC     = valid ? head.pc : '0;
  assign bus.OCCUPANCY = count;

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue (DEPTH 4) plus program-order scoreboards on DEPTH 2 and 8.
module tb_otter_fetch_queue;
  import otter_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic sb_on = 1'b0;

  logic        r_ready [2];
  logic        r_redir [2];
  logic [31:0] r_tgt   [2];

  always #5 clk = ~clk;

  otter_fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus4 ();

  otter_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_VEC(32'h0)) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus4)
  );

  // Memory returns 0x1000_0000 | address one cycle after the strobe.
  always @(posedge clk) if (bus4.MEM_READ1) bus4.MEM_DOUT1 <= 32'h1000_0000 | bus4.MEM_ADDR1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Leaves the caller just after the edge that starts cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    bus4.REDIRECT = 1'b0;
    adv(2);
    rst = 1'b0;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int D = (g == 0) ? 2 : 8;
    otter_fetch_queue_if #(.XLEN(32), .DEPTH(D)) bx ();
    otter_fetch_queue #(.XLEN(32), .DEPTH(D), .RESET_VEC(32'h0)) u_dut (
      .CLK (clk),
      .RST (rst),
      .bus (bx)
    );
    assign bx.IF_READY    = r_ready[g];
    assign bx.REDIRECT    = r_redir[g];
    assign bx.REDIRECT_PC = r_tgt[g];
    always @(posedge clk) if (bx.MEM_READ1) bx.MEM_DOUT1 <= 32'h1000_0000 | bx.MEM_ADDR1;

    logic [31:0] exp_pc = 32'h0;
    int          n_del  = 0;
    always @(negedge clk) begin
      if (rst) exp_pc = 32'h0;
      else if (sb_on) begin
        if (bx.IF_VALID && bx.IF_READY) begin
          check($sformatf("d%0d_pc", D), bx.IF_PC, exp_pc);
          check($sformatf("d%0d_ir", D), bx.IF_IR, 32'h1000_0000 | exp_pc);
          exp_pc = exp_pc + 32'd4;
          n_del++;
        end
        if (bx.REDIRECT) exp_pc = bx.REDIRECT_PC & 32'hFFFF_FFFC;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      r_ready[g] = 1'b0;
      r_redir[g] = 1'b0;
      r_tgt[g]   = 32'h0;
    end
    bus4.IF_READY    = 1'b1;
    bus4.REDIRECT    = 1'b0;
    bus4.REDIRECT_PC = 32'h0;

    // Reset state and streaming after release.
    adv(1);
    smp();
    check("rst_valid", 32'(bus4.IF_VALID), 32'd0);
    check("rst_ir", bus4.IF_IR, 32'h0000_0013);
    check("rst_pc", bus4.IF_PC, 32'h0);
    check("rst_occ", 32'(bus4.OCCUPANCY), 32'd0);
    check("rst_read", 32'(bus4.MEM_READ1), 32'd0);
    check("rst_addr", bus4.MEM_ADDR1, 32'h0);
    adv(1);
    rst = 1'b0;
    smp();
    check("c0_read", 32'(bus4.MEM_READ1), 32'd1);
    check("c0_addr", bus4.MEM_ADDR1, 32'h0);
    check("c0_valid", 32'(bus4.IF_VALID), 32'd0);
    adv(1);
    smp();
    check("c1_valid", 32'(bus4.IF_VALID), 32'd0);
    for (int k = 0; k < 8; k++) begin
      adv(1);
      smp();
      check("str_valid", 32'(bus4.IF_VALID), 32'd1);
      check("str_pc", bus4.IF_PC, 32'(4 * k));
      check("str_ir", bus4.IF_IR, 32'h1000_0000 | 32'(4 * k));
    end

    // Back-pressure: queue saturates, then drains in order without a gap.
    adv(1);
    bus4.IF_READY = 1'b0;
    do_reset();
    adv(9);
    smp();
    check("bp_occ", 32'(bus4.OCCUPANCY), 32'd4);
    check("bp_read", 32'(bus4.MEM_READ1), 32'd0);
    check("bp_pc", bus4.IF_PC, 32'h0);
    adv(1);
    bus4.IF_READY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp();
      check("bp_valid", 32'(bus4.IF_VALID), 32'd1);
      check("bp_dpc", bus4.IF_PC, 32'(4 * k));
      check("bp_dir", bus4.IF_IR, 32'h1000_0000 | 32'(4 * k));
      adv(1);
    end

    // Redirect with three queued entries and a read in flight.
    bus4.IF_READY = 1'b0;
    do_reset();
    adv(4);
    bus4.REDIRECT    = 1'b1;
    bus4.REDIRECT_PC = 32'h0000_0103;
    smp();
    check("rd_occ_pre", 32'(bus4.OCCUPANCY), 32'd3);
    check("rd_read_blk", 32'(bus4.MEM_READ1), 32'd0);
    adv(1);
    bus4.REDIRECT = 1'b0;
    smp();
    check("rd_occ_post", 32'(bus4.OCCUPANCY), 32'd0);
    check("rd_valid1", 32'(bus4.IF_VALID), 32'd0);
    check("rd_addr", bus4.MEM_ADDR1, 32'h0000_0100);
    check("rd_read", 32'(bus4.MEM_READ1), 32'd1);
    adv(1);
    smp();
    check("rd_valid2", 32'(bus4.IF_VALID), 32'd0);
    adv(1);
    bus4.IF_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("rd_valid", 32'(bus4.IF_VALID), 32'd1);
      check("rd_pc", bus4.IF_PC, 32'h100 + 32'(4 * k));
      check("rd_ir", bus4.IF_IR, 32'h1000_0100 + 32'(4 * k));
      adv(1);
    end

    // Back-to-back redirects: the second target wins.
    do_reset();
    adv(5);
    bus4.REDIRECT    = 1'b1;
    bus4.REDIRECT_PC = 32'h40;
    smp();
    check("rr_read0", 32'(bus4.MEM_READ1), 32'd0);
    adv(1);
    bus4.REDIRECT_PC = 32'h80;
    smp();
    check("rr_read1", 32'(bus4.MEM_READ1), 32'd0);
    check("rr_occ", 32'(bus4.OCCUPANCY), 32'd0);
    adv(1);
    bus4.REDIRECT = 1'b0;
    smp();
    check("rr_addr", bus4.MEM_ADDR1, 32'h80);
    check("rr_read2", 32'(bus4.MEM_READ1), 32'd1);
    adv(1);
    smp();
    check("rr_valid", 32'(bus4.IF_VALID), 32'd0);
    for (int k = 0; k < 3; k++) begin
      adv(1);
      smp();
      check("rr_pc", bus4.IF_PC, 32'h80 + 32'(4 * k));
    end

    // Asynchronous reset between edges while streaming.
    do_reset();
    adv(6);
    smp();
    check("ar_pre_pc", bus4.IF_PC, 32'd16);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(bus4.IF_VALID), 32'd0);
    check("ar_occ", 32'(bus4.OCCUPANCY), 32'd0);
    check("ar_read", 32'(bus4.MEM_READ1), 32'd0);
    check("ar_ir", bus4.IF_IR, 32'h0000_0013);
    adv(2);
    rst = 1'b0;
    adv(2);
    smp();
    check("ar_pc0", bus4.IF_PC, 32'h0);
    check("ar_ir0", bus4.IF_IR, 32'h1000_0000);
    adv(1);
    smp();
    check("ar_pc4", bus4.IF_PC, 32'h4);

    // Random ready/redirect traffic on the DEPTH 2 and 8 instances.
    do_reset();
    sb_on = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      for (int g = 0; g < 2; g++) begin
        r_ready[g] = ($urandom_range(0, 99) < 65);
        r_redir[g] = ($urandom_range(0, 99) < 3);
        r_tgt[g]   = 32'($urandom_range(0, 32'h3ff));
      end
      adv(1);
    end
    for (int g = 0; g < 2; g++) begin
      r_ready[g] = 1'b0;
      r_redir[g] = 1'b0;
    end
    smp();
    sb_on = 1'b0;
    check("d2_deliv", 32'(g_rnd[0].n_del > 300), 32'd1);
    check("d8_deliv", 32'(g_rnd[1].n_del > 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
